// File: rtl/module_display_pkg.sv
// Shared constants for the display path: segment patterns, FSM states, BCD range.
// Segment patterns are {g,f,e,d,c,b,a}, active-low.
package module_display_pkg;

  typedef enum logic {
    IDLE,
    CONVERT
  } state_t;

  localparam int BCD_MAX = 9999;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

  // Non-decimal nibbles render blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/module_bin2bcd_seq.sv
// Sequential double-dabble: one add-3/shift iteration per cycle, DATA_W iterations.
// Ports: clk, rst, valid_i/data_i load, busy_o, bcd_o (complete results only), err_o.
module module_bin2bcd_seq
  import module_display_pkg::*;
#(
  parameter int DATA_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              busy_o,
  output logic [15:0]       bcd_o,
  output logic              err_o
);

  localparam int ITER_W = $clog2(DATA_W + 1);

  state_t            state;
  logic [DATA_W-1:0] bin;
  logic [15:0]       scratch;
  logic [ITER_W-1:0] iter;

  logic [15:0]       adj;
  logic [15:0]       next_bcd;
  logic [DATA_W-1:0] next_bin;
  logic [31:0]       data_ext;
  logic              in_range;
  logic              last_iter;

  always_comb begin
    adj = scratch;
    for (int k = 0; k < 4; k++) begin
      if (scratch[4*k +: 4] >= 4'd5)
        adj[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
    end
    next_bcd = {adj[14:0], bin[DATA_W-1]};
    next_bin = {bin[DATA_W-2:0], 1'b0};
  end

  assign data_ext  = 32'(data_i);
  assign in_range  = data_ext <= 32'(BCD_MAX);
  assign last_iter = iter == ITER_W'(DATA_W - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bin     <= '0;
      scratch <= '0;
      iter    <= '0;
      busy_o  <= 1'b0;
      bcd_o   <= '0;
      err_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_i) begin
            if (in_range) begin
              bin     <= data_i;
              scratch <= '0;
              iter    <= '0;
              busy_o  <= 1'b1;
              state   <= CONVERT;
            end else begin
              err_o <= 1'b1;
            end
          end
        end
        CONVERT: begin
          scratch <= next_bcd;
          bin     <= next_bin;
          iter    <= iter + 1'b1;
          if (last_iter) begin
            bcd_o  <= next_bcd;
            busy_o <= 1'b0;
            err_o  <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/module_display_scan.sv
// Binary-to-7-segment scanner: sequential BCD conversion, 4-digit multiplexed drive.
// Ports: clk, rst, valid_i, data_i, busy_o, err_o, bcd_o, anodo_o (active-low), seg_o (active-low).
// Optional: LEADING_ZERO_BLANK_EN blanks leading zeros on the upper three digits.
module module_display_scan
  import module_display_pkg::*;
#(
  parameter int DATA_W      = 14,
  parameter int REFRESH_DIV = 27000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              busy_o,
  output logic              err_o,
  output logic [15:0]       bcd_o,
  output logic [3:0]        anodo_o,
  output logic [6:0]        seg_o
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [1:0]       idx;
  logic [1:0]       idx_next;
  logic             wrap;
  logic [3:0]       nib;
  logic             blank;
  logic [6:0]       seg_next;

  module_bin2bcd_seq #(
    .DATA_W (DATA_W)
  ) u_bin2bcd (
    .clk     (clk),
    .rst     (rst),
    .valid_i (valid_i),
    .data_i  (data_i),
    .busy_o  (busy_o),
    .bcd_o   (bcd_o),
    .err_o   (err_o)
  );

  assign wrap     = cnt == CNT_W'(REFRESH_DIV - 1);
  assign cnt_next = wrap ? '0 : cnt + 1'b1;
  assign idx_next = wrap ? idx + 2'd1 : idx;

  // Decode for the digit about to be shown so anode and segments
  // switch together on the same edge.
  always_comb begin
    nib   = bcd_o[3:0];
    blank = 1'b0;
    case (idx_next)
      2'd0: nib = bcd_o[3:0];
      2'd1: nib = bcd_o[7:4];
      2'd2: nib = bcd_o[11:8];
      2'd3: nib = bcd_o[15:12];
      default: nib = bcd_o[3:0];
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    case (idx_next)
      2'd3: blank = bcd_o[15:12] == 4'd0;
      2'd2: blank = bcd_o[15:8] == 8'd0;
      2'd1: blank = bcd_o[15:4] == 12'd0;
      default: blank = 1'b0;
    endcase
`else
    blank = 1'b0;
`endif
    if (err_o)
      seg_next = SEG_DASH;
    else if (blank)
      seg_next = SEG_BLANK;
    else
      seg_next = seg_decode(nib);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      idx     <= 2'd0;
      anodo_o <= 4'b1111;
      seg_o   <= SEG_BLANK;
    end else begin
      cnt     <= cnt_next;
      idx     <= idx_next;
      anodo_o <= ~(4'b0001 << idx_next);
      seg_o   <= seg_next;
    end
  end

endmodule

// File: tb/tb_module_display_scan.sv
// Directed self-checking bench for module_display_scan (REFRESH_DIV = 4).
// Hand-computed BCD results and segment patterns; immediate assertions per check.
module tb_module_display_scan;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic [13:0] data_i;
  logic        busy_o;
  logic        err_o;
  logic [15:0] bcd_o;
  logic [3:0]  anodo_o;
  logic [6:0]  seg_o;

  int checks;
  int errors;

  module_display_scan #(
    .DATA_W      (14),
    .REFRESH_DIV (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .valid_i (valid_i),
    .data_i  (data_i),
    .busy_o  (busy_o),
    .err_o   (err_o),
    .bcd_o   (bcd_o),
    .anodo_o (anodo_o),
    .seg_o   (seg_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] exp_seg(input int d, input logic [15:0] b, input logic e);
    logic [6:0] tab [10];
    logic [3:0] n;
    tab[0] = 7'b1000000; tab[1] = 7'b1111001; tab[2] = 7'b0100100;
    tab[3] = 7'b0110000; tab[4] = 7'b0011001; tab[5] = 7'b0010010;
    tab[6] = 7'b0000010; tab[7] = 7'b1111000; tab[8] = 7'b0000000;
    tab[9] = 7'b0010000;
    if (e) return 7'b0111111;
    n = b[4*d +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    if (d > 0) begin
      logic z;
      z = 1'b1;
      for (int k = d; k < 4; k++)
        if (b[4*k +: 4] != 4'd0) z = 1'b0;
      if (z) return 7'b1111111;
    end
`endif
    if (n > 4'd9) return 7'b1111111;
    return tab[n];
  endfunction

  task automatic convert(input string tag, input logic [13:0] d, input logic [15:0] exp);
    valid_i = 1'b1;
    data_i  = d;
    step();
    valid_i = 1'b0;
    chk({tag, "_busy_start"}, 32'(busy_o), 32'd1);
    repeat (13) step();
    chk({tag, "_busy_last"}, 32'(busy_o), 32'd1);
    step();
    chk({tag, "_busy_done"}, 32'(busy_o), 32'd0);
    chk({tag, "_bcd"}, 32'(bcd_o), 32'(exp));
  endtask

  task automatic scan_check(input string tag, input logic [15:0] b, input logic e);
    logic [3:0] seen;
    int d;
    seen = 4'b0000;
    for (int c = 0; c < 16; c++) begin
      step();
      d = -1;
      case (anodo_o)
        4'b1110: d = 0;
        4'b1101: d = 1;
        4'b1011: d = 2;
        4'b0111: d = 3;
        default: d = -1;
      endcase
      chk({tag, "_anode_onehot"}, 32'(d >= 0), 32'd1);
      if (d >= 0) begin
        seen[d] = 1'b1;
        chk($sformatf("%s_seg_d%0d", tag, d), 32'(seg_o), 32'(exp_seg(d, b, e)));
      end
    end
    chk({tag, "_all_anodes"}, 32'(seen), 32'hF);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    valid_i = 1'b0;
    data_i  = '0;
    #1;
    chk("rst_anodo", 32'(anodo_o), 32'hF);
    chk("rst_seg", 32'(seg_o), 32'h7F);
    chk("rst_bcd", 32'(bcd_o), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_err", 32'(err_o), 32'h0);
    step();
    step();
    rst = 1'b0;
    step();
    chk("first_anodo", 32'(anodo_o), 32'hE);
    chk("first_seg", 32'(seg_o), 32'h40);

    convert("c1234", 14'd1234, 16'h1234);
    scan_check("s1234", 16'h1234, 1'b0);

    convert("c9801", 14'd9801, 16'h9801);
    scan_check("s9801", 16'h9801, 1'b0);

    valid_i = 1'b1;
    data_i  = 14'd10000;
    step();
    valid_i = 1'b0;
    chk("e10000_err", 32'(err_o), 32'd1);
    chk("e10000_busy", 32'(busy_o), 32'd0);
    chk("e10000_bcd", 32'(bcd_o), 32'h9801);
    scan_check("s_err", 16'h9801, 1'b1);

    valid_i = 1'b1;
    data_i  = 14'd5;
    step();
    valid_i = 1'b0;
    chk("c5_err_held", 32'(err_o), 32'd1);
    repeat (14) step();
    chk("c5_err_clear", 32'(err_o), 32'd0);
    chk("c5_bcd", 32'(bcd_o), 32'h0005);

    convert("c0", 14'd0, 16'h0000);

    convert("c7", 14'd7, 16'h0007);
    scan_check("s7", 16'h0007, 1'b0);

    valid_i = 1'b1;
    data_i  = 14'd1234;
    step();
    valid_i = 1'b0;
    repeat (3) step();
    valid_i = 1'b1;
    data_i  = 14'd42;
    step();
    valid_i = 1'b0;
    chk("ign_busy", 32'(busy_o), 32'd1);
    repeat (10) step();
    chk("ign_busy_done", 32'(busy_o), 32'd0);
    chk("ign_bcd", 32'(bcd_o), 32'h1234);
    step();
    chk("ign_idle", 32'(busy_o), 32'd0);

    valid_i = 1'b1;
    data_i  = 14'd4321;
    step();
    valid_i = 1'b0;
    repeat (6) step();
    chk("mid_busy", 32'(busy_o), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy_o), 32'd0);
    chk("mid_rst_bcd", 32'(bcd_o), 32'h0);
    chk("mid_rst_anodo", 32'(anodo_o), 32'hF);
    chk("mid_rst_seg", 32'(seg_o), 32'h7F);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_anodo", 32'(anodo_o), 32'hE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/module_display_scan.md
Name: module_display_scan

Overview:
Output-side counterpart of the keypad scanner. The keypad path scans columns and samples rows to turn key presses into BCD operands; this block goes the other way and turns binary values into time-multiplexed 7-segment drive.
- Accepts a 14-bit binary value (operand or product, max 99*99 = 9801) on a strobe.
- Converts it to 4-digit BCD with a sequential double-dabble.
- Scans the four digits onto shared segment lines with one-hot anode drive.

Parameters:
- DATA_W, 14, binary input width.
- REFRESH_DIV, 27000, clk cycles each digit stays lit (1 ms at 27 MHz).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- valid_i  input  1  single-cycle load strobe for data_i
- data_i  input  DATA_W  binary value to display
- busy_o  output  1  conversion in progress
- err_o  output  1  last accepted value was >= 10000
- bcd_o  output  16  last completed BCD result: {thousands, hundreds, tens, units}
- anodo_o  output  4  digit enable, active-low, one-hot; bit0 = units
- seg_o  output  7  {g,f,e,d,c,b,a}, active-low

Behaviour:
- Reset (asynchronous, any state):
  - busy_o=0, err_o=0, bcd_o=16'h0000.
  - anodo_o=4'b1111, seg_o=7'b1111111.
  - FSM to IDLE, digit index 0, refresh counter 0.
- FSM states: IDLE, CONVERT.
- IDLE:
  - valid_i=1 with data_i <= 9999: latch data_i into the shift register, clear the BCD scratch, iteration count 0, go to CONVERT; busy_o=1 from the next cycle.
  - valid_i=1 with data_i >= 10000: stay in IDLE; err_o=1 next cycle; bcd_o unchanged.
  - Any accepted in-range value clears err_o when its conversion completes.
- CONVERT, one iteration per cycle, DATA_W iterations:
  - Each BCD nibble >= 5 gets +3.
  - Then shift {bcd, bin} left by 1.
  - After the last iteration, bcd_o takes the result, busy_o=0, return to IDLE.
  - Latency: bcd_o valid and busy_o low on cycle DATA_W+1 after the valid_i edge (15 with the default).
- valid_i during CONVERT is ignored; no queueing.
- bcd_o is only ever written with a complete result; the display never shows partial scratch.
- Scan:
  - Refresh counter runs 0..REFRESH_DIV-1 continuously, independent of the FSM.
  - On wrap, the digit index advances 0→1→2→3→0.
  - From the first clk edge after reset release, anodo_o = ~(4'b0001 << index).
- Segments:
  - seg_o decodes the selected nibble of bcd_o.
  - 0=7'b1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Nibble > 9 shows blank (1111111).
  - When err_o=1, every digit shows a dash (7'b0111111).
- anodo_o and seg_o are registered and change on the same edge.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: thousands/hundreds/tens digits that are zero and have no nonzero digit above them show seg_o=7'b1111111 while their anode is still scanned. The units digit is never blanked.
- Undefined: all four digits are always displayed.

Decomposition:
- Package module_display_pkg:
  - Segment constants: SEG_BLANK, SEG_DASH, and the digit patterns 0–9.
  - Enum typedef for the FSM states.
  - BCD_MAX = 9999.
- Sub-module module_bin2bcd_seq: the double-dabble FSM with valid_i, data_i, busy_o, bcd_o, err_o.
- The top level keeps the refresh counter, digit mux and segment decode.

Test Plan (REFRESH_DIV=4):
- Hold rst=1, then release: during reset anodo_o=1111, seg_o=1111111, bcd_o=0. First edge after release gives anodo_o=1110, seg_o=1000000.
- valid_i with data_i=1234: busy_o=1 for 14 cycles, bcd_o=16'h1234 on cycle 15. Over the next 16 cycles the scan shows 4,3,2,1 on anodes 1110,1101,1011,0111.
- data_i=9801 gives bcd_o=16'h9801; data_i=0 gives 16'h0000.
- data_i=10000: err_o=1, bcd_o keeps its previous value, all digits show 0111111. A following data_i=5 clears err_o on completion.
- valid_i=1234, then valid_i=42 at cycle 5: 42 is ignored and the result is 16'h1234. Asserting rst at cycle 7 of a new conversion gives busy_o=0 and bcd_o=0 immediately.
- With LEADING_ZERO_BLANK_EN, data_i=7: anodes 0111, 1011 and 1101 drive 1111111, anode 1110 drives 1111000. Without the macro, the three upper digits show 1000000.
